pe8_rr_arbiter: RTL and testbench
=================================

Name: pe8_rr_arbiter

Overview:
- 8-requester arbiter that shares one resource, with grant hold and forced timeout release.
- Selects a winner with an 8-to-3 MSB priority encoder.
- Round-robin rotation prevents starvation; fixed-priority mode is selectable.
- Sits between up to 8 request sources and a single shared datapath. The downstream mux select is gnt_id; gnt_vld qualifies it.

Parameters:
- RR_EN, 1, 1 = descending round-robin; 0 = fixed MSB priority (index 7 highest).
- MAX_HOLD, 16, maximum consecutive cycles one grant is held before forced release. Range 1..255.
- CNT_W, 8, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable. Low blocks new grants; it does not revoke the current grant.
- req  input  8  request vector; bit k is requester k. A requester holds its bit high for as long as it wants the resource.
- gnt  output  8  one-hot grant, registered.
- gnt_id  output  3  binary index of the granted requester, registered.
- gnt_vld  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse, the cycle after a grant is forcibly released.

Behaviour:
- Reset values: gnt=0, gnt_id=0, gnt_vld=0, timeout=0, state=IDLE, hold_cnt=0, last_id=0. rst overrides all other inputs.
- States:
  - IDLE: no grant.
  - GRANT: gnt[gnt_id]=1.
- Winner selection, combinational, evaluated in IDLE:
  - mask = bits strictly below last_id, i.e. (1<<last_id)-1.
  - mreq = req & mask.
  - If RR_EN=1 and mreq != 0, winner = MSB index of mreq. Otherwise winner = MSB index of req.
  - Consequence: after a grant to k, the search order is k-1 down to 0, then 7 down to k.
- IDLE -> GRANT when en=1 and req != 0.
  - Registered outputs at the next edge: gnt=1<<winner, gnt_id=winner, gnt_vld=1, hold_cnt=1, last_id=winner.
  - Latency is 1 cycle: req high in cycle n gives gnt in cycle n+1.
- IDLE with en=0 or req=0: stay in IDLE with outputs 0.
- GRANT, req[gnt_id]=1 and hold_cnt<MAX_HOLD: stay in GRANT and increment hold_cnt. Changes on other req bits are ignored.
- GRANT, req[gnt_id]=0: go to IDLE and clear gnt/gnt_vld at the next edge. No timeout pulse.
- GRANT, req[gnt_id]=1 and hold_cnt==MAX_HOLD: go to IDLE, clear gnt, and set timeout=1 for exactly one cycle.
- Grant-to-grant gap: gnt_vld is low for at least one cycle between any two grants, including re-grant of the same requester.
- gnt_id holds its last value while gnt_vld=0. Consumers must qualify gnt_id with gnt_vld.
- en dropping during GRANT has no effect until the grant releases.
- RR_EN=0: last_id is still updated but ignored; selection is pure MSB priority.
- If release by req drop and timeout expiry occur in the same cycle, req drop wins and no timeout pulse is issued.
- Invariants:
  - gnt is always 0 or one-hot.
  - gnt == (gnt_vld ? 1<<gnt_id : 0).

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - requester-count constant NREQ=8.
  - index-width constant IDX_W=3.
- Sub-module pe8_msb_enc: 8-to-3 MSB priority encoder with a valid output (valid = |in).
  - Instantiate twice: once on mreq, once on req.
  - A 3-bit 2:1 select on the mreq valid chooses the winner.
- Hold counter and FSM stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with req=8'hFF -> gnt=0, gnt_vld=0, timeout=0 throughout. First grant appears 1 cycle after rst drops: gnt_id=7, gnt=8'h80.
- Single request: req=8'h04 for 3 cycles, then 0 -> gnt=8'h04 for 3 cycles starting 1 cycle after req rises; gnt_vld low the cycle after req drops.
- Round-robin fairness (RR_EN=1): req=8'hFF, with each requester dropping its bit one cycle after being granted and re-raising it one cycle later -> gnt_id sequence 7,6,5,4,3,2,1,0,7, with a 1-cycle gap between grants.
- Timeout (MAX_HOLD=4): req=8'h10 held continuously -> gnt high for exactly 4 cycles, timeout pulse 1 cycle, gnt_vld low 1 cycle, then re-grant to 4.
- Fixed mode (RR_EN=0): req=8'h81 with the granted bit toggled off and on as above -> gnt_id stays 7 on every grant; requester 0 is never granted.
- Mid-operation: assert rst while gnt=8'h20 -> gnt=0 at the next edge. Separately, drop en while granted -> grant persists until req[5] drops, and no new grant is issued while en=0.

Source files
------------

// File: rtl/pe8_rr_arbiter_pkg.sv
// Shared types and constants for the 8-requester round-robin arbiter.
// Holds the FSM state type and the requester/index sizing used by all blocks.
package pe8_rr_arbiter_pkg;

    localparam int unsigned NREQ  = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef logic [NREQ-1:0]  req_vec_t;
    typedef logic [IDX_W-1:0] req_idx_t;

    // Requests strictly below idx, i.e. (1<<idx)-1.
    function automatic req_vec_t below_mask(input req_idx_t idx);
        return (req_vec_t'(1) << idx) - req_vec_t'(1);
    endfunction

    function automatic req_vec_t onehot(input req_idx_t idx);
        return req_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/pe8_rr_arbiter_msb_enc.sv
// 8-to-3 MSB priority encoder: idx is the highest set bit of in, valid = |in.
// idx is 0 when no bit is set.
module pe8_msb_enc
    import pe8_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  in,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (in[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign valid = |in;

endmodule

// File: rtl/pe8_rr_arbiter.sv
// 8-requester arbiter with descending round-robin (or fixed MSB) priority,
// grant hold while the owner keeps requesting, and forced release after MAX_HOLD cycles.
module pe8_rr_arbiter
    import pe8_rr_arbiter_pkg::*;
#(
    parameter int unsigned RR_EN    = 1,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             gnt_vld,
    output logic             timeout
);

    state_t           state_q, state_n;
    logic [NREQ-1:0]  gnt_q, gnt_n;
    logic [IDX_W-1:0] id_q, id_n;
    logic [IDX_W-1:0] last_q, last_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             to_q, to_n;

    logic [NREQ-1:0]  mreq;
    logic [IDX_W-1:0] m_idx, r_idx, winner;
    logic             m_vld, r_vld;

    assign mreq = req & below_mask(last_q);

    pe8_msb_enc u_enc_masked (
        .in    (mreq),
        .idx   (m_idx),
        .valid (m_vld)
    );

    pe8_msb_enc u_enc_raw (
        .in    (req),
        .idx   (r_idx),
        .valid (r_vld)
    );

    // Masked search only applies in round-robin mode; otherwise plain MSB priority.
    assign winner = ((RR_EN != 0) && m_vld) ? m_idx : r_idx;

    always_comb begin
        state_n = state_q;
        gnt_n   = gnt_q;
        id_n    = id_q;
        last_n  = last_q;
        cnt_n   = cnt_q;
        to_n    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && r_vld) begin
                    state_n = ST_GRANT;
                    gnt_n   = onehot(winner);
                    id_n    = winner;
                    last_n  = winner;
                    cnt_n   = CNT_W'(1);
                end
            end
            ST_GRANT: begin
                // Request drop takes precedence over expiry: no timeout pulse then.
                if (!req[id_q]) begin
                    state_n = ST_IDLE;
                    gnt_n   = '0;
                end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
                    state_n = ST_IDLE;
                    gnt_n   = '0;
                    to_n    = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            id_q    <= id_n;
            last_q  <= last_n;
            cnt_q   <= cnt_n;
            to_q    <= to_n;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = id_q;
    assign gnt_vld = (state_q == ST_GRANT);
    assign timeout = to_q;

endmodule

// File: tb/tb_pe8_rr_arbiter.sv
// Directed bench for pe8_rr_arbiter: three instances cover round-robin,
// short MAX_HOLD expiry and fixed-priority modes.
module tb_pe8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req_rr, req_to, req_fx;

    logic [7:0] gnt_rr, gnt_to, gnt_fx;
    logic [2:0] id_rr, id_to, id_fx;
    logic       vld_rr, vld_to, vld_fx;
    logic       to_rr, to_to, to_fx;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pe8_rr_arbiter #(.RR_EN(1), .MAX_HOLD(16), .CNT_W(8)) dut_rr (
        .clk(clk), .rst(rst), .en(en), .req(req_rr),
        .gnt(gnt_rr), .gnt_id(id_rr), .gnt_vld(vld_rr), .timeout(to_rr)
    );

    pe8_rr_arbiter #(.RR_EN(1), .MAX_HOLD(4), .CNT_W(8)) dut_to (
        .clk(clk), .rst(rst), .en(en), .req(req_to),
        .gnt(gnt_to), .gnt_id(id_to), .gnt_vld(vld_to), .timeout(to_to)
    );

    pe8_rr_arbiter #(.RR_EN(0), .MAX_HOLD(16), .CNT_W(8)) dut_fx (
        .clk(clk), .rst(rst), .en(en), .req(req_fx),
        .gnt(gnt_fx), .gnt_id(id_fx), .gnt_vld(vld_fx), .timeout(to_fx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rr(input string tag, input logic [7:0] g, input logic [2:0] id,
                            input logic v, input logic t);
        check({tag, "_gnt"}, 32'(gnt_rr), 32'(g));
        if (v) check({tag, "_id"}, 32'(id_rr), 32'(id));
        check({tag, "_vld"}, 32'(vld_rr), 32'(v));
        check({tag, "_to"}, 32'(to_rr), 32'(t));
    endtask

    task automatic check_to(input string tag, input logic [7:0] g, input logic v, input logic t);
        check({tag, "_gnt"}, 32'(gnt_to), 32'(g));
        check({tag, "_vld"}, 32'(vld_to), 32'(v));
        check({tag, "_to"}, 32'(to_to), 32'(t));
    endtask

    initial begin
        logic [2:0] exp_id;
        logic [2:0] prev_id;

        rst = 1'b1; en = 1'b1; req_rr = 8'hFF; req_to = 8'h00; req_fx = 8'h00;

        // Reset dominates requests.
        step(); check_rr("rst0", 8'h00, 3'd0, 1'b0, 1'b0);
        check("rst0_id", 32'(id_rr), 32'd0);
        step(); check_rr("rst1", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); check_rr("first", 8'h80, 3'd7, 1'b1, 1'b0);

        // Round-robin walk 7..0 then back to 7, one-cycle gap each time.
        prev_id = 3'd7;
        for (int i = 1; i <= 8; i++) begin
            exp_id = (i < 8) ? 3'(7 - i) : 3'd7;
            req_rr = 8'hFF & ~(8'h01 << prev_id);
            step(); check_rr("rr_gap", 8'h00, 3'd0, 1'b0, 1'b0);
            req_rr = 8'hFF;
            step(); check_rr("rr_gnt", 8'h01 << exp_id, exp_id, 1'b1, 1'b0);
            prev_id = exp_id;
        end
        req_rr = 8'h00;
        step(); check_rr("rr_end", 8'h00, 3'd0, 1'b0, 1'b0);
        check("idle_id_hold", 32'(id_rr), 32'd7);

        // Single request held three cycles.
        req_rr = 8'h04;
        step(); check_rr("single1", 8'h04, 3'd2, 1'b1, 1'b0);
        step(); check_rr("single2", 8'h04, 3'd2, 1'b1, 1'b0);
        step(); check_rr("single3", 8'h04, 3'd2, 1'b1, 1'b0);
        req_rr = 8'h00;
        step(); check_rr("single_rel", 8'h00, 3'd0, 1'b0, 1'b0);

        // Timeout: MAX_HOLD=4 with a continuously held request.
        req_to = 8'h10;
        step(); check_to("to_h1", 8'h10, 1'b1, 1'b0);
        check("to_id", 32'(id_to), 32'd4);
        step(); check_to("to_h2", 8'h10, 1'b1, 1'b0);
        step(); check_to("to_h3", 8'h10, 1'b1, 1'b0);
        step(); check_to("to_h4", 8'h10, 1'b1, 1'b0);
        step(); check_to("to_pulse", 8'h00, 1'b0, 1'b1);
        step(); check_to("to_regnt", 8'h10, 1'b1, 1'b0);
        step(); check_to("to_r2", 8'h10, 1'b1, 1'b0);
        step(); check_to("to_r3", 8'h10, 1'b1, 1'b0);
        step(); check_to("to_r4", 8'h10, 1'b1, 1'b0);
        // Drop coincides with expiry: release without pulse.
        req_to = 8'h00;
        step(); check_to("to_drop", 8'h00, 1'b0, 1'b0);
        step(); check_to("to_quiet", 8'h00, 1'b0, 1'b0);

        // Fixed priority: requester 7 always wins over 0.
        req_fx = 8'h81;
        step();
        check("fx_gnt0", 32'(gnt_fx), 32'h80);
        check("fx_id0", 32'(id_fx), 32'd7);
        for (int i = 0; i < 3; i++) begin
            req_fx = 8'h01;
            step(); check("fx_gap", 32'(gnt_fx), 32'h00);
            req_fx = 8'h81;
            step();
            check("fx_gnt", 32'(gnt_fx), 32'h80);
            check("fx_id", 32'(id_fx), 32'd7);
        end
        req_fx = 8'h00;

        // Reset while granted.
        req_rr = 8'h20;
        step(); check_rr("mid_gnt", 8'h20, 3'd5, 1'b1, 1'b0);
        rst = 1'b1;
        step(); check_rr("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // en low keeps the current grant but blocks new ones.
        step(); check_rr("en_gnt", 8'h20, 3'd5, 1'b1, 1'b0);
        en = 1'b0; req_rr = 8'h3F;
        step(); check_rr("en_hold1", 8'h20, 3'd5, 1'b1, 1'b0);
        step(); check_rr("en_hold2", 8'h20, 3'd5, 1'b1, 1'b0);
        req_rr = 8'h1F;
        step(); check_rr("en_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        step(); check_rr("en_block1", 8'h00, 3'd0, 1'b0, 1'b0);
        step(); check_rr("en_block2", 8'h00, 3'd0, 1'b0, 1'b0);
        en = 1'b1;
        step(); check_rr("en_resume", 8'h10, 3'd4, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
